// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the per-slot state enum, default timing and the blank segment code.
package sseg_pkg;

  typedef enum logic [1:0] {
    S_BLANK,
    S_ON,
    S_OFF
  } scanState_e;

  localparam int SCAN_DIV_DEF  = 12500;
  localparam int BLANK_CYC_DEF = 500;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder, active-low cathodes {g..a}.
module seg7_decode
  import sseg_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    case (i_value)
      4'h0: o_seg = 7'h40;
      4'h1: o_seg = 7'h79;
      4'h2: o_seg = 7'h24;
      4'h3: o_seg = 7'h30;
      4'h4: o_seg = 7'h19;
      4'h5: o_seg = 7'h12;
      4'h6: o_seg = 7'h02;
      4'h7: o_seg = 7'h78;
      4'h8: o_seg = 7'h00;
      4'h9: o_seg = 7'h10;
      4'hA: o_seg = 7'h08;
      4'hB: o_seg = 7'h03;
      4'hC: o_seg = 7'h46;
      4'hD: o_seg = 7'h21;
      4'hE: o_seg = 7'h06;
      4'hF: o_seg = 7'h0E;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Eight-digit seven-segment scan scheduler with blank interval, PWM brightness,
// leading-zero suppression and a frame-synchronous shadow register set.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] digits_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  input  logic [3:0]  brightness,
  input  logic        load,
  output logic [6:0]  sseg,
  output logic        dp,
  output logic [7:0]  AN,
  output logic        frame_tick
);

  localparam int              CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [31:0]     BLANK_LEN = 32'(BLANK_CYC);
  localparam logic [31:0]     ON_STEP   = 32'((SCAN_DIV - BLANK_CYC) >> 4);

  logic [CW-1:0] r_slotCnt;
  logic [2:0]    r_slotIdx;
  logic          r_pending;
  logic [31:0]   r_shDigits;
  logic [7:0]    r_shDp;
  logic [7:0]    r_shEn;
  logic          r_shLz;
  logic [3:0]    r_shBright;
  scanState_e    r_state;
  logic [7:0]    r_an;
  logic [6:0]    r_sseg;
  logic          r_dp;
  logic          r_frameTick;

  scanState_e    w_stateNext;
  logic          w_slotEnd;
  logic          w_frameEnd;
  logic [CW-1:0] w_cntNext;
  logic [31:0]   w_cntNext32;
  logic [31:0]   w_onEnd;
  logic [7:0]    w_visible;
  logic [3:0]    w_selDigit;
  logic [6:0]    w_segCode;

  assign w_slotEnd   = (r_slotCnt == CNT_MAX);
  assign w_frameEnd  = w_slotEnd && (r_slotIdx == 3'd7);
  assign w_cntNext   = w_slotEnd ? '0 : r_slotCnt + CW'(1);
  assign w_cntNext32 = 32'(w_cntNext);
  assign w_onEnd     = BLANK_LEN + ON_STEP * (32'(r_shBright) + 32'd1);
  assign w_selDigit  = r_shDigits[{r_slotIdx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slotCnt <= '0;
      r_slotIdx <= '0;
    end else begin
      r_slotCnt <= w_cntNext;
      if (w_slotEnd) r_slotIdx <= r_slotIdx + 3'd1;
    end
  end

  // Inputs reach the shadow only on the 7->0 wrap, so a frame is never torn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending  <= 1'b0;
      r_shDigits <= '0;
      r_shDp     <= '0;
      r_shEn     <= '0;
      r_shLz     <= 1'b0;
      r_shBright <= 4'hF;
    end else if (w_frameEnd) begin
      r_pending <= 1'b0;
      if (r_pending || load) begin
        r_shDigits <= digits_in;
        r_shDp     <= dp_in;
        r_shEn     <= digit_en;
        r_shLz     <= lz_blank;
        r_shBright <= brightness;
      end
    end else if (load) begin
      r_pending <= 1'b1;
    end
  end

  // Walk from the most significant digit down, hiding zeros until an enabled non-zero digit appears.
  always_comb begin
    logic seenNz;
    seenNz    = 1'b0;
    w_visible = r_shEn;
    for (int i = 7; i >= 0; i--) begin
      if (r_shLz && (i != 0) && !seenNz && (r_shDigits[4*i +: 4] == 4'd0))
        w_visible[i] = 1'b0;
      if (r_shEn[i] && (r_shDigits[4*i +: 4] != 4'd0))
        seenNz = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_BLANK;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_BLANK: if (w_cntNext32 >= BLANK_LEN) w_stateNext = S_ON;
      S_ON: begin
        if (w_slotEnd)                   w_stateNext = S_BLANK;
        else if (w_cntNext32 >= w_onEnd) w_stateNext = S_OFF;
      end
      S_OFF:   if (w_slotEnd) w_stateNext = S_BLANK;
      default: w_stateNext = S_BLANK;
    endcase
  end

  seg7_decode u_decode (
    .i_value (w_selDigit),
    .o_seg   (w_segCode)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an        <= AN_OFF;
      r_sseg      <= SEG_OFF;
      r_dp        <= 1'b1;
      r_frameTick <= 1'b0;
    end else begin
      r_frameTick <= w_frameEnd;
      if ((r_state == S_ON) && w_visible[r_slotIdx]) begin
        r_an   <= ~(8'd1 << r_slotIdx);
        r_sseg <= w_segCode;
        r_dp   <= ~r_shDp[r_slotIdx];
      end else begin
        r_an   <= AN_OFF;
        r_sseg <= SEG_OFF;
        r_dp   <= 1'b1;
      end
    end
  end

  assign AN         = r_an;
  assign sseg       = r_sseg;
  assign dp         = r_dp;
  assign frame_tick = r_frameTick;

endmodule
